// File: rtl/holy_core_pkg.sv
// holy_core_pkg: shared core types used by the MDU arbiter slice.
//   alu_control_t   - ALU/MDU operation encoding carried with each request
//   mdu_arb_state_t - arbiter FSM states
//   is_mdu_op()     - true for the RV32M operations that need the mul_div_unit
package holy_core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_control_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } mdu_arb_state_t;

    // Operations that must be run on the mul_div_unit.
    function automatic logic is_mdu_op(input alu_control_t ctrl);
        logic m;
        m = 1'b0;
        case (ctrl)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: m = 1'b1;
            default:                              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mdu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req_i - request vector
//   ptr_i - index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o - one-hot grant (all zero when nothing requested)
//   idx_o - binary index of the grant
//   any_o - at least one request present
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // First requester after the pointer wins; the pointer itself is tried last.
    always_comb begin : pick
        int unsigned cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(ptr_i) + off) % NUM_REQ;
            if (!any_o && req_i[IDX_W'(cand)]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
                gnt_o = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one mul_div_unit between NUM_REQ requesters.
//   rq_valid/rq_src1/rq_src2/rq_ctrl - per-requester operation request
//   rq_kill       - per-requester flush of pending/in-flight op
//   rq_ready      - one-cycle one-hot accept pulse
//   rs_valid/rs_data/rs_ack - one-hot result valid, shared result bus, consume
//   mdu_req_valid/mdu_src1/mdu_src2/mdu_control - issue side of the MDU
//   mdu_res_valid/mdu_res_ack/mdu_result        - result side of the MDU
//   busy          - arbiter not idle
module mdu_arbiter
    import holy_core_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             rq_valid,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   rq_src1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   rq_src2,
    input  alu_control_t [NUM_REQ-1:0]     rq_ctrl,
    input  logic [NUM_REQ-1:0]             rq_kill,
    output logic [NUM_REQ-1:0]             rq_ready,
    output logic [NUM_REQ-1:0]             rs_valid,
    output logic [XLEN-1:0]                rs_data,
    input  logic [NUM_REQ-1:0]             rs_ack,
    output logic                           mdu_req_valid,
    output logic [XLEN-1:0]                mdu_src1,
    output logic [XLEN-1:0]                mdu_src2,
    output alu_control_t                   mdu_control,
    input  logic                           mdu_res_valid,
    output logic                           mdu_res_ack,
    input  logic [XLEN-1:0]                mdu_result,
    output logic                           busy
);

    mdu_arb_state_t     state_q, state_d;

    logic [XLEN-1:0]    src1_q, src1_d;
    logic [XLEN-1:0]    src2_q, src2_d;
    alu_control_t       ctrl_q, ctrl_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               drop_q, drop_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    alu_control_t       pick_ctrl;
    logic               gnt_kill;
    logic               gnt_ack;
    logic [NUM_REQ-1:0] gnt_onehot;

    // A killed requester is never granted, even if it still holds valid.
    assign eligible   = rq_valid & ~rq_kill;
    assign pick_ctrl  = rq_ctrl[pick_idx];
    assign gnt_kill   = rq_kill[gnt_idx_q];
    assign gnt_ack    = rs_ack[gnt_idx_q];
    assign gnt_onehot = NUM_REQ'(1) << gnt_idx_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A dropped op still waits for the MDU so it is acked.
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = is_mdu_op(pick_ctrl) ? ARB_ISSUE : ARB_RESP;
                end
            end
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT: begin
                if (mdu_res_valid) begin
                    state_d = (drop_q || gnt_kill) ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (gnt_ack || gnt_kill) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin : fsm_out
        rq_ready      = '0;
        mdu_req_valid = 1'b0;
        mdu_res_ack   = 1'b0;
        rs_valid      = '0;
        rs_data       = '0;
        busy          = (state_q != ARB_IDLE);
        case (state_q)
            ARB_IDLE:  rq_ready      = pick_gnt;
            ARB_ISSUE: mdu_req_valid = 1'b1;
            ARB_WAIT:  mdu_res_ack   = mdu_res_valid;
            ARB_RESP: begin
                rs_valid = gnt_onehot;
                rs_data  = result_q;
            end
            default: ;
        endcase
    end

    // Operand/result capture and drop-flag tracking.
    always_comb begin : dp_next
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        drop_d    = drop_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    src1_d    = rq_src1[pick_idx];
                    src2_d    = rq_src2[pick_idx];
                    ctrl_d    = pick_ctrl;
                    gnt_idx_d = pick_idx;
                    rr_ptr_d  = pick_idx;
                    // Non-M ops return zero without touching the MDU.
                    result_d  = '0;
                    drop_d    = 1'b0;
                end
            end
            ARB_ISSUE: begin
                if (gnt_kill) begin
                    drop_d = 1'b1;
                end
            end
            ARB_WAIT: begin
                if (gnt_kill) begin
                    drop_d = 1'b1;
                end
                if (mdu_res_valid) begin
                    result_d = mdu_result;
                    drop_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : dp_reg
        if (!rst_n) begin
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= ALU_ADD;
            result_q  <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            drop_q    <= 1'b0;
        end else begin
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            drop_q    <= drop_d;
        end
    end

    assign mdu_src1    = src1_q;
    assign mdu_src2    = src2_q;
    assign mdu_control = ctrl_q;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Testbench for mdu_arbiter with a behavioural mul_div_unit model.
module tb_mdu_arbiter;
    import holy_core_pkg::*;

    localparam int unsigned NR = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NR-1:0]          rq_valid;
    logic [NR-1:0][31:0]    rq_src1;
    logic [NR-1:0][31:0]    rq_src2;
    alu_control_t [NR-1:0]  rq_ctrl;
    logic [NR-1:0]          rq_kill;
    logic [NR-1:0]          rq_ready;
    logic [NR-1:0]          rs_valid;
    logic [31:0]            rs_data;
    logic [NR-1:0]          rs_ack;
    logic                   mdu_req_valid;
    logic [31:0]            mdu_src1;
    logic [31:0]            mdu_src2;
    alu_control_t           mdu_control;
    logic                   mdu_res_valid;
    logic                   mdu_res_ack;
    logic [31:0]            mdu_result;
    logic                   busy;

    logic                   mdl_pend;
    int                     mdl_cnt;
    logic [31:0]            mdl_res;

    int n_checks;
    int n_fail;

    mdu_arbiter #(.NUM_REQ(NR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rq_valid      (rq_valid),
        .rq_src1       (rq_src1),
        .rq_src2       (rq_src2),
        .rq_ctrl       (rq_ctrl),
        .rq_kill       (rq_kill),
        .rq_ready      (rq_ready),
        .rs_valid      (rs_valid),
        .rs_data       (rs_data),
        .rs_ack        (rs_ack),
        .mdu_req_valid (mdu_req_valid),
        .mdu_src1      (mdu_src1),
        .mdu_src2      (mdu_src2),
        .mdu_control   (mdu_control),
        .mdu_res_valid (mdu_res_valid),
        .mdu_res_ack   (mdu_res_ack),
        .mdu_result    (mdu_result),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M reference result.
    function automatic logic [31:0] ref_mdu(input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            ALU_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'h0;
        endcase
    endfunction

    // Cycles from req_valid to res_valid of the MDU model.
    function automatic int ref_lat(input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_DIV, ALU_REM:   return ((b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 33;
            ALU_DIVU, ALU_REMU: return (b == 0) ? 2 : 33;
            default:            return 1;
        endcase
    endfunction

    // Behavioural mul_div_unit: result held until acked.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_res_valid <= 1'b0;
            mdu_result    <= 32'h0;
            mdl_pend      <= 1'b0;
            mdl_cnt       <= 0;
            mdl_res       <= 32'h0;
        end else begin
            if (mdu_res_valid && mdu_res_ack) mdu_res_valid <= 1'b0;
            if (mdu_req_valid) begin
                if (ref_lat(mdu_control, mdu_src1, mdu_src2) == 1) begin
                    mdu_res_valid <= 1'b1;
                    mdu_result    <= ref_mdu(mdu_control, mdu_src1, mdu_src2);
                end else begin
                    mdl_pend <= 1'b1;
                    mdl_cnt  <= ref_lat(mdu_control, mdu_src1, mdu_src2) - 1;
                    mdl_res  <= ref_mdu(mdu_control, mdu_src1, mdu_src2);
                end
            end else if (mdl_pend) begin
                if (mdl_cnt == 1) begin
                    mdu_res_valid <= 1'b1;
                    mdu_result    <= mdl_res;
                    mdl_pend      <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int           idx;
        alu_control_t ctrl;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [NR-1:0] kmask;
        logic [31:0]  exp_data;
        int           exp_lat;
        int           exp_nreq;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op from v.idx, wait for its result and ack it.
    task automatic do_op(input vec_t v, output bit granted, output int lat, output logic [31:0] data,
                         output int nreq, output bit stable, output logic [NR-1:0] rv);
        int t;
        granted = 1'b0; lat = -1; data = '0; nreq = 0; stable = 1'b1; rv = '0;
        rq_src1[v.idx] = v.a;
        rq_src2[v.idx] = v.b;
        rq_ctrl[v.idx] = v.ctrl;
        rq_valid[v.idx] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rq_ready[v.idx]) begin granted = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!granted) begin
            rq_valid[v.idx] = 1'b0;
            return;
        end
        t = 0;
        while (t < 100) begin
            @(posedge clk); #1;
            t++;
            if (t == 1) rq_valid[v.idx] = 1'b0;
            if (t == 2) rq_kill = v.kmask;
            if (t == 3) rq_kill = '0;
            @(negedge clk);
            if (mdu_req_valid) nreq++;
            if (rs_valid != '0) begin
                lat = t; data = rs_data; rv = rs_valid;
                break;
            end
            if (mdu_src1 !== v.a || mdu_src2 !== v.b || mdu_control !== v.ctrl) stable = 1'b0;
        end
        rq_kill = '0;
        if (lat > 0) begin
            rs_ack[v.idx] = 1'b1;
            @(posedge clk); #1;
            rs_ack[v.idx] = 1'b0;
        end
    endtask

    // From the negedge of a grant cycle, wait for rs_valid[idx]; lat=-1 on timeout.
    task automatic wait_rs(input int idx, output int lat);
        int t;
        t = 0;
        lat = -1;
        while (t < 100) begin
            @(posedge clk); #1;
            t++;
            if (t == 1) rq_valid[idx] = 1'b0;
            @(negedge clk);
            if (rs_valid[idx]) begin lat = t; break; end
        end
    endtask

    initial begin
        bit              granted, stable, rs_seen, b_seen;
        int              lat, nreq, t_rv, t_idle, n_ack, n_gr;
        logic [31:0]     data;
        logic [NR-1:0]   rv;
        logic [NR-1:0]   gr_log[8];

        n_checks = 0;
        n_fail   = 0;
        rq_valid = '0;
        rq_src1  = '0;
        rq_src2  = '0;
        rq_ctrl  = {ALU_ADD, ALU_ADD};
        rq_kill  = '0;
        rs_ack   = '0;
        for (int i = 0; i < 8; i++) gr_log[i] = '0;

        vecs[0] = '{0, ALU_MUL,   32'd7,         32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB, 3,  1};
        vecs[1] = '{1, ALU_DIVU,  32'h0000_1234, 32'h0,         2'b00, 32'hFFFF_FFFF, 4,  1};
        vecs[2] = '{0, ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h0,         4,  1};
        vecs[3] = '{1, ALU_ADD,   32'd5,         32'd6,         2'b00, 32'h0,         1,  0};
        vecs[4] = '{0, ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 3,  1};
        vecs[5] = '{0, ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 4,  1};
        vecs[6] = '{0, ALU_MUL,   32'd3,         32'd5,         2'b10, 32'h0000_000F, 3,  1};
        vecs[7] = '{1, ALU_DIV,   32'hFFFF_FF9C, 32'd7,         2'b00, 32'hFFFF_FFF2, 35, 1};
        vecs[8] = '{1, ALU_MULH,  32'h8000_0000, 32'd2,         2'b00, 32'hFFFF_FFFF, 3,  1};

        // Reset state.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",     32'(busy), 32'h0);
        check("rst_outs",     {26'b0, rq_ready, rs_valid, mdu_req_valid, mdu_res_ack}, 32'h0);
        check("rst_rs_data",  rs_data, 32'h0);
        check("rst_src",      mdu_src1 | mdu_src2, 32'h0);
        check("rst_control",  32'(mdu_control), 32'(ALU_ADD));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Valid with kill on the same index is not eligible.
        rq_ctrl[0] = ALU_MUL; rq_valid[0] = 1'b1; rq_kill[0] = 1'b1;
        @(negedge clk);
        check("killed_not_granted", 32'(rq_ready), 32'h0);
        @(posedge clk); #1;
        rq_valid = '0; rq_kill = '0;
        @(negedge clk);
        check("killed_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;

        // Simultaneous DIV (req0) and REMU (req1): req0 first, req1 back-to-back.
        rq_ctrl[0] = ALU_DIV;  rq_src1[0] = 32'd100; rq_src2[0] = 32'd7;
        rq_ctrl[1] = ALU_REMU; rq_src1[1] = 32'd100; rq_src2[1] = 32'd7;
        rq_valid = 2'b11;
        @(negedge clk);
        check("sim_grant0", 32'(rq_ready), 32'h1);
        wait_rs(0, lat);
        check("sim_div_lat", 32'(lat), 32'd35);
        check("sim_div_data", rs_data, 32'd14);
        rs_ack[0] = 1'b1;
        @(posedge clk); #1;
        rs_ack[0] = 1'b0;
        @(negedge clk);
        check("sim_grant1_b2b", 32'(rq_ready), 32'h2);
        wait_rs(1, lat);
        check("sim_remu_lat", 32'(lat), 32'd35);
        check("sim_remu_data", rs_data, 32'd2);
        rs_ack[1] = 1'b1;
        @(posedge clk); #1;
        rs_ack[1] = 1'b0;

        // Table of single operations.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i], granted, lat, data, nreq, stable, rv);
            check($sformatf("v%0d_grant", i),  32'(granted), 32'h1);
            check($sformatf("v%0d_lat", i),    32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_data", i),   data, vecs[i].exp_data);
            check($sformatf("v%0d_onehot", i), 32'(rv), 32'(1) << vecs[i].idx);
            check($sformatf("v%0d_nreq", i),   32'(nreq), 32'(vecs[i].exp_nreq));
            check($sformatf("v%0d_stable", i), 32'(stable), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_idle", i),   {31'b0, busy} | rs_data, 32'h0);
            @(posedge clk); #1;
        end

        // Fairness: both continuously valid with MUL, acked immediately.
        rq_ctrl = {ALU_MUL, ALU_MUL};
        rq_src1 = {32'd2, 32'd3};
        rq_src2 = {32'd4, 32'd5};
        rq_valid = 2'b11;
        n_gr = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rs_ack = rs_valid;
            if (rq_ready != '0) begin
                if (n_gr < 8) gr_log[n_gr] = rq_ready;
                n_gr++;
            end
            @(posedge clk); #1;
        end
        rq_valid = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rs_ack = rs_valid;
            if (!busy) break;
            @(posedge clk); #1;
        end
        rs_ack = '0;
        @(posedge clk); #1;
        check("fair_count_ge4", 32'(n_gr >= 4), 32'h1);
        check("fair_g0", 32'(gr_log[0]), 32'h1);
        check("fair_g1", 32'(gr_log[1]), 32'h2);
        check("fair_g2", 32'(gr_log[2]), 32'h1);
        check("fair_g3", 32'(gr_log[3]), 32'h2);

        // Kill during WAIT of a DIV: MDU still acked once, no result delivered.
        rq_ctrl[0] = ALU_DIV; rq_src1[0] = 32'd100; rq_src2[0] = 32'd7;
        rq_valid[0] = 1'b1;
        @(negedge clk);
        check("killw_grant", 32'(rq_ready), 32'h1);
        t_rv = -1; t_idle = -1; n_ack = 0; rs_seen = 1'b0;
        for (int t = 1; t < 100; t++) begin
            @(posedge clk); #1;
            if (t == 1) rq_valid[0] = 1'b0;
            if (t == 4) rq_kill[0] = 1'b1;
            if (t == 5) rq_kill[0] = 1'b0;
            @(negedge clk);
            if (mdu_res_ack) n_ack++;
            if (rs_valid[0]) rs_seen = 1'b1;
            if (mdu_res_valid && t_rv < 0) t_rv = t;
            if (!busy) begin t_idle = t; break; end
        end
        check("killw_ack_once", 32'(n_ack), 32'd1);
        check("killw_no_rs", 32'(rs_seen), 32'h0);
        check("killw_idle_next", 32'(t_idle), 32'(t_rv + 1));
        @(posedge clk); #1;

        // Kill in RESP of a non-M op from req1.
        rq_ctrl[1] = ALU_ADD; rq_src1[1] = 32'd1; rq_src2[1] = 32'd1;
        rq_valid[1] = 1'b1;
        @(negedge clk);
        check("killr_grant", 32'(rq_ready), 32'h2);
        @(posedge clk); #1;
        rq_valid[1] = 1'b0;
        rq_kill[1]  = 1'b1;
        @(negedge clk);
        check("killr_resp", {30'b0, rs_valid} | {31'b0, mdu_req_valid} << 4, 32'h2);
        @(posedge clk); #1;
        rq_kill[1] = 1'b0;
        @(negedge clk);
        check("killr_dropped", {30'b0, rs_valid} | {31'b0, busy} << 4, 32'h0);
        @(posedge clk); #1;

        // Async reset in the middle of a DIV.
        rq_ctrl[0] = ALU_DIV; rq_src1[0] = 32'd1000; rq_src2[0] = 32'd3;
        rq_valid[0] = 1'b1;
        @(negedge clk);
        check("rstmid_grant", 32'(rq_ready), 32'h1);
        @(posedge clk); #1;
        rq_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_outs", {26'b0, rq_ready, rs_valid, mdu_req_valid, mdu_res_ack}, 32'h0);
        check("rstmid_data", rs_data | mdu_src1 | mdu_src2, 32'h0);
        check("rstmid_control", 32'(mdu_control), 32'(ALU_ADD));
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (rs_valid != '0 || busy || mdu_res_valid) b_seen = 1'b1;
        end
        check("rstmid_no_result", 32'(b_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
